midi_tx_engine: RTL and testbench
=================================

Name: midi_tx_engine

Overview:
Synthesizable, parametrised MIDI serial transmitter. It is the successor to our fixed-pattern behavioural MIDI stimulus. It accepts whole MIDI messages (1–3 bytes) over a valid/ready handshake and serialises them at the MIDI bit rate. Line polarity, bit order and inter-byte gap are configurable, with optional running-status compression. It sits between the note sequencer/test controller and the MIDI output pin, and also acts as a bench driver for our MIDI UART receiver.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency.
BAUD, 31250, serial bit rate; DIVISOR = CLK_FREQ_HZ/BAUD (integer, must be >= 2; elaboration error otherwise).
IDLE_LEVEL, 0, line level between frames.
START_LEVEL, 1, start-bit level.
STOP_LEVEL, 1, stop-bit level.
MSB_FIRST, 1, 1 = bit 7 sent first, 0 = bit 0 first.
GAP_BITS, 1, idle bit periods after each stop bit (0..7).
RUNNING_STATUS, 0, 1 = omit repeated channel-voice status bytes.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
msg_valid  in  1  message offered
msg_ready  out  1  engine can accept a message
msg_status  in  8  status byte
msg_data1  in  8  first data byte
msg_data2  in  8  second data byte
msg_len  in  2  bytes in message (1..3; 0 = null message)
tx  out  1  serial MIDI line
busy  out  1  frame/message in progress
byte_done  out  1  one-cycle pulse at end of each byte's stop bit

Behaviour:
- Reset values (asynchronous, immediate): tx = IDLE_LEVEL, msg_ready = 1, busy = 0, byte_done = 0.
  - Reset also clears the running-status register, the divider and all counters.
- Acceptance and busy:
  - A message is accepted on the rising edge where msg_valid && msg_ready; all fields are registered then.
  - msg_ready = !busy. Inputs are ignored while busy.
  - busy rises the cycle after acceptance.
  - Message length 0: accepted, nothing sent, busy never rises, running status unchanged.
- FSM states: IDLE -> START -> DATA -> STOP -> GAP -> (next byte ? START : IDLE).
  - GAP is skipped when GAP_BITS = 0.
  - Each state other than IDLE lasts exactly DIVISOR clocks per bit period, timed by the baud tick.
  - The divider restarts on acceptance, so the first start bit is driven on tx the cycle after acceptance.
- DATA: 8 bit periods; bit order per MSB_FIRST; data bits are not inverted.
- byte_done pulses on the final cycle of STOP.
- Message end: busy falls, and msg_ready rises, on the cycle after the last bit period of the final byte's GAP (or STOP if GAP_BITS = 0).
- Frame length: 10 + GAP_BITS bit periods. With defaults, a 3-byte message = 33 bit periods = 33*DIVISOR clocks.
- Byte selection: byte index 0..msg_len-1 maps to status, data1, data2.
- Running status (RUNNING_STATUS = 1):
  - Channel-voice status 0x80–0xEF equal to the stored status: the status byte is skipped and data bytes only are sent.
  - Channel-voice status otherwise: the status byte is sent and stored.
  - 0xF0–0xF7: sent, stored status cleared.
  - 0xF8–0xFF (realtime): sent, stored status unaffected.
  - If skipping the status leaves 0 bytes, the message behaves as the null case.
- Reset mid-frame: tx returns to IDLE_LEVEL asynchronously; the partial message is discarded, not resumed.

Decomposition:
- Shared package midi_pkg holds:
  - status constants: NOTE_OFF 0x80, NOTE_ON 0x90, SYSEX 0xF0, CLOCK 0xF8;
  - is_channel_voice() and is_realtime() functions;
  - FSM state typedef.
- Sub-module midi_baud_gen (parameter DIVISOR): ports clk, rst_n, restart, tick. tick pulses once every DIVISOR clocks; restart zeroes the count.

Test Plan:
1. Reset with CLK_FREQ_HZ=125000 (DIVISOR=4) -> tx=0, msg_ready=1, busy=0 until the first message.
2. Note-on 0x90/0x2A/0x33, len 3, defaults:
   - tx per 4-clock period: 1,1001 0000,1,0 then 1,0010 1010,1,0 then 1,0011 0011,1,0;
   - three byte_done pulses;
   - msg_ready back high at clock 133.
3. RUNNING_STATUS=1: 0x90/2A/33 then 0x90/2A/00 -> second message 2 frames (88 clocks), no status byte. Then 0x80/2A/33 -> status 0x80 sent.
4. RUNNING_STATUS=1: 0x90 note, then 0xF8 len 1, then 0x90 note -> status omitted. After 0xF0 len 1, next 0x90 -> status sent.
5. IDLE_LEVEL=1, START_LEVEL=0, MSB_FIRST=0, byte 0x90 len 1 -> tx 0,0000 1001,1,1 then idle 1.
6. rst_n low for 1 ns mid-DATA of 2nd byte -> tx=IDLE_LEVEL immediately, busy=0, msg_ready=1. Next 0x90 message sends its status byte.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status constants, status classifiers and the
// transmitter FSM state type.
`timescale 1ns/1ps
package midi_pkg;

    localparam logic [7:0] NOTE_OFF = 8'h80;
    localparam logic [7:0] NOTE_ON  = 8'h90;
    localparam logic [7:0] SYSEX    = 8'hF0;
    localparam logic [7:0] CLOCK    = 8'hF8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } tx_state_t;

    // 0x80..0xEF
    function automatic logic is_channel_voice(input logic [7:0] s);
        return s[7] && (s[7:4] != 4'hF);
    endfunction

    // 0xF8..0xFF
    function automatic logic is_realtime(input logic [7:0] s);
        return s[7:3] == 5'b11111;
    endfunction

endpackage

// File: rtl/midi_tx_engine_if.sv
// midi_tx_engine_if: message handshake bundle (valid/ready + 1..3 bytes).
// master = message source, slave = transmitter.
`timescale 1ns/1ps
interface midi_tx_engine_if;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [7:0] msg_data1;
    logic [7:0] msg_data2;
    logic [1:0] msg_len;

    modport master (
        output msg_valid, msg_status, msg_data1, msg_data2, msg_len,
        input  msg_ready
    );

    modport slave (
        input  msg_valid, msg_status, msg_data1, msg_data2, msg_len,
        output msg_ready
    );
endinterface

// File: rtl/midi_baud_gen.sv
// midi_baud_gen: bit-period tick generator.
// Ports: clk, rst_n, restart (zero count), tick (1 clk every DIVISOR clks).
`timescale 1ns/1ps
module midi_baud_gen #(
    parameter int DIVISOR = 1600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/midi_tx_engine.sv
// midi_tx_engine: MIDI serialiser for 1..3 byte messages with optional
// running status. Ports: clk, rst_n, msg (slave), tx, busy, byte_done.
`timescale 1ns/1ps
module midi_tx_engine
    import midi_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int BAUD           = 31250,
    parameter bit IDLE_LEVEL     = 1'b0,
    parameter bit START_LEVEL    = 1'b1,
    parameter bit STOP_LEVEL     = 1'b1,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int GAP_BITS       = 1,
    parameter bit RUNNING_STATUS = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    midi_tx_engine_if.slave   msg,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);
    localparam int DIVISOR = CLK_FREQ_HZ / BAUD;
    localparam logic [2:0] GAP_LAST =
        3'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    if (DIVISOR < 2) begin : g_bad_div
        $error("midi_tx_engine: CLK_FREQ_HZ/BAUD must be >= 2");
    end
    if (GAP_BITS < 0 || GAP_BITS > 7) begin : g_bad_gap
        $error("midi_tx_engine: GAP_BITS must be 0..7");
    end

    tx_state_t  r_state;
    logic       r_tx;
    logic       r_busy;
    logic [7:0] r_shift;
    logic [7:0] r_b1;
    logic [7:0] r_b2;
    logic [7:0] r_rs;
    logic [1:0] r_n;
    logic [1:0] r_idx;
    logic [2:0] r_bit;
    logic [2:0] r_gap;

    logic       w_tick;
    logic       w_accept;
    logic       w_skip;
    logic [1:0] w_n;
    logic [7:0] w_shift_nxt;
    logic       w_bit_cur;
    logic       w_bit_nxt;
    logic       w_more;
    logic       w_frame_end;

    midi_baud_gen #(.DIVISOR(DIVISOR)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_accept),
        .tick    (w_tick)
    );

    assign msg.msg_ready = !r_busy;
    assign tx            = r_tx;
    assign busy          = r_busy;
    // Decoded from registered state and the divider count only.
    assign byte_done     = (r_state == ST_STOP) && w_tick;

    assign w_accept = msg.msg_valid && !r_busy;
    assign w_skip   = RUNNING_STATUS && (msg.msg_len != 2'd0)
                   && is_channel_voice(msg.msg_status)
                   && (msg.msg_status == r_rs);
    assign w_n      = w_skip ? msg.msg_len - 2'd1 : msg.msg_len;

    assign w_shift_nxt = MSB_FIRST ? {r_shift[6:0], 1'b0}
                                   : {1'b0, r_shift[7:1]};
    assign w_bit_cur   = MSB_FIRST ? r_shift[7] : r_shift[0];
    assign w_bit_nxt   = MSB_FIRST ? w_shift_nxt[7] : w_shift_nxt[0];

    assign w_more      = (r_idx + 2'd1) < r_n;
    assign w_frame_end = w_tick &&
        (((r_state == ST_STOP) && (GAP_BITS == 0)) ||
         ((r_state == ST_GAP) && (r_gap == GAP_LAST)));

    // Stored status only changes for messages that actually carry bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs <= 8'h00;
        end else if (RUNNING_STATUS && w_accept && msg.msg_len != 2'd0) begin
            if (is_channel_voice(msg.msg_status)) begin
                r_rs <= msg.msg_status;
            end else if (!is_realtime(msg.msg_status)) begin
                r_rs <= 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tx    <= IDLE_LEVEL;
            r_busy  <= 1'b0;
            r_shift <= 8'h00;
            r_b1    <= 8'h00;
            r_b2    <= 8'h00;
            r_n     <= 2'd0;
            r_idx   <= 2'd0;
            r_bit   <= 3'd0;
            r_gap   <= 3'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_n != 2'd0) begin
                        r_state <= ST_START;
                        r_tx    <= START_LEVEL;
                        r_busy  <= 1'b1;
                        r_shift <= w_skip ? msg.msg_data1 : msg.msg_status;
                        r_b1    <= w_skip ? msg.msg_data2 : msg.msg_data1;
                        r_b2    <= msg.msg_data2;
                        r_n     <= w_n;
                        r_idx   <= 2'd0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state <= ST_DATA;
                        r_tx    <= w_bit_cur;
                        r_bit   <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= STOP_LEVEL;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= w_shift_nxt;
                            r_tx    <= w_bit_nxt;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick && GAP_BITS != 0) begin
                        r_state <= ST_GAP;
                        r_tx    <= IDLE_LEVEL;
                        r_gap   <= 3'd0;
                    end
                end
                ST_GAP: begin
                    if (w_tick && r_gap != GAP_LAST) begin
                        r_gap <= r_gap + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_frame_end) begin
                if (w_more) begin
                    r_state <= ST_START;
                    r_tx    <= START_LEVEL;
                    r_idx   <= r_idx + 2'd1;
                    r_shift <= (r_idx == 2'd0) ? r_b1 : r_b2;
                end else begin
                    r_state <= ST_IDLE;
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_midi_tx_engine.sv
// tb_midi_tx_engine: directed bench, three engines at DIVISOR = 4:
// defaults, running status, and inverted/LSB-first line.
`timescale 1ns/1ps
module tb_midi_tx_engine;
    localparam int CLK_HZ = 125000;
    localparam int BD     = 31250;

    localparam bit [10:0] F90 = 11'b1_1001_0000_1_0;
    localparam bit [10:0] F2A = 11'b1_0010_1010_1_0;
    localparam bit [10:0] F33 = 11'b1_0011_0011_1_0;
    localparam bit [10:0] F00 = 11'b1_0000_0000_1_0;
    localparam bit [10:0] F80 = 11'b1_1000_0000_1_0;
    localparam bit [10:0] F40 = 11'b1_0100_0000_1_0;
    localparam bit [10:0] F7F = 11'b1_0111_1111_1_0;
    localparam bit [10:0] FF8 = 11'b1_1111_1000_1_0;
    localparam bit [10:0] FF0 = 11'b1_1111_0000_1_0;
    localparam bit [10:0] C90 = 11'b0_0000_1001_1_1;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic tx_a, tx_b, tx_c;
    logic busy_a, busy_b, busy_c;
    logic bd_a, bd_b, bd_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    midi_tx_engine_if ifa ();
    midi_tx_engine_if ifb ();
    midi_tx_engine_if ifc ();

    midi_tx_engine #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD(BD)
    ) u_a (
        .clk(clk), .rst_n(rst_a), .msg(ifa.slave),
        .tx(tx_a), .busy(busy_a), .byte_done(bd_a)
    );

    midi_tx_engine #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD(BD), .RUNNING_STATUS(1'b1)
    ) u_b (
        .clk(clk), .rst_n(rst_b), .msg(ifb.slave),
        .tx(tx_b), .busy(busy_b), .byte_done(bd_b)
    );

    midi_tx_engine #(
        .CLK_FREQ_HZ(CLK_HZ), .BAUD(BD), .IDLE_LEVEL(1'b1),
        .START_LEVEL(1'b0), .MSB_FIRST(1'b0)
    ) u_c (
        .clk(clk), .rst_n(rst_c), .msg(ifc.slave),
        .tx(tx_c), .busy(busy_c), .byte_done(bd_c)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        case (sel)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic bd_of(input int sel);
        case (sel)
            0:       return bd_a;
            1:       return bd_b;
            default: return bd_c;
        endcase
    endfunction

    function automatic logic rdy_of(input int sel);
        case (sel)
            0:       return ifa.msg_ready;
            1:       return ifb.msg_ready;
            default: return ifc.msg_ready;
        endcase
    endfunction

    task automatic set_msg(input int sel, input logic v, input logic [7:0] s,
                           input logic [7:0] d1, input logic [7:0] d2,
                           input logic [1:0] l);
        case (sel)
            0: begin
                ifa.msg_valid = v; ifa.msg_status = s;
                ifa.msg_data1 = d1; ifa.msg_data2 = d2; ifa.msg_len = l;
            end
            1: begin
                ifb.msg_valid = v; ifb.msg_status = s;
                ifb.msg_data1 = d1; ifb.msg_data2 = d2; ifb.msg_len = l;
            end
            default: begin
                ifc.msg_valid = v; ifc.msg_status = s;
                ifc.msg_data1 = d1; ifc.msg_data2 = d2; ifc.msg_len = l;
            end
        endcase
    endtask

    // Offer one message for exactly one rising edge (the acceptance edge).
    task automatic offer(input int sel, input logic [7:0] s,
                         input logic [7:0] d1, input logic [7:0] d2,
                         input logic [1:0] l);
        @(negedge clk);
        chk("rdy_pre", rdy_of(sel), 1);
        set_msg(sel, 1'b1, s, d1, d2, l);
        @(posedge clk);
        #1;
        set_msg(sel, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
    endtask

    // Sample every cycle after acceptance; pat holds nper bit periods,
    // first period in the MSB.
    task automatic run_frames(input int sel, input logic [32:0] pat,
                              input int nper, input logic idle,
                              input string tag);
        int pulses = 0;
        for (int p = 0; p < nper; p++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                chk({tag, "_tx"}, tx_of(sel), pat[nper-1-p]);
                if (j == 0 || (p == nper - 1 && j == 3)) begin
                    chk({tag, "_busy"}, busy_of(sel), 1);
                    chk({tag, "_rdy_lo"}, rdy_of(sel), 0);
                end
                if (bd_of(sel)) pulses++;
            end
        end
        @(negedge clk);
        chk({tag, "_rdy_end"}, rdy_of(sel), 1);
        chk({tag, "_busy_end"}, busy_of(sel), 0);
        chk({tag, "_tx_idle"}, tx_of(sel), idle);
        chk({tag, "_bdone_cnt"}, pulses, nper / 11);
    endtask

    task automatic expect_null(input int sel, input logic idle,
                               input string tag);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk({tag, "_busy"}, busy_of(sel), 0);
            chk({tag, "_rdy"}, rdy_of(sel), 1);
            chk({tag, "_tx"}, tx_of(sel), idle);
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int s = 0; s < 3; s++) begin
            set_msg(s, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0);
        end
        repeat (3) @(negedge clk);
        chk("rst_tx_a", tx_a, 0);
        chk("rst_tx_c", tx_c, 1);
        chk("rst_rdy_a", ifa.msg_ready, 1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_bd_a", bd_a, 0);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_tx_a", tx_a, 0);
            chk("idle_rdy_a", ifa.msg_ready, 1);
            chk("idle_busy_a", busy_a, 0);
        end

        // Full note-on, default framing.
        offer(0, 8'h90, 8'h2A, 8'h33, 2'd3);
        run_frames(0, {F90, F2A, F33}, 33, 1'b0, "note3");

        // Null message.
        offer(0, 8'h90, 8'h2A, 8'h33, 2'd0);
        expect_null(0, 1'b0, "len0");

        // Running status.
        offer(1, 8'h90, 8'h2A, 8'h33, 2'd3);
        run_frames(1, {F90, F2A, F33}, 33, 1'b0, "rs_first");
        offer(1, 8'h90, 8'h2A, 8'h00, 2'd3);
        run_frames(1, {11'd0, F2A, F00}, 22, 1'b0, "rs_skip");
        offer(1, 8'h80, 8'h2A, 8'h33, 2'd3);
        run_frames(1, {F80, F2A, F33}, 33, 1'b0, "rs_new");

        // Realtime keeps stored status; sysex clears it.
        offer(1, 8'h90, 8'h40, 8'h7F, 2'd3);
        run_frames(1, {F90, F40, F7F}, 33, 1'b0, "rs_n1");
        offer(1, 8'h90, 8'h55, 8'h00, 2'd1);
        expect_null(1, 1'b0, "rs_empty");
        offer(1, 8'hF8, 8'h00, 8'h00, 2'd1);
        run_frames(1, {22'd0, FF8}, 11, 1'b0, "rs_clk");
        offer(1, 8'h90, 8'h40, 8'h00, 2'd3);
        run_frames(1, {11'd0, F40, F00}, 22, 1'b0, "rs_after_rt");
        offer(1, 8'hF0, 8'h00, 8'h00, 2'd1);
        run_frames(1, {22'd0, FF0}, 11, 1'b0, "rs_sysex");
        offer(1, 8'h90, 8'h40, 8'h7F, 2'd3);
        run_frames(1, {F90, F40, F7F}, 33, 1'b0, "rs_after_sx");

        // Inverted line, LSB first.
        offer(2, 8'h90, 8'h00, 8'h00, 2'd1);
        run_frames(2, {22'd0, C90}, 11, 1'b1, "pol");

        // Reset in the middle of the 2nd byte's data bits.
        offer(1, 8'h90, 8'h2A, 8'h33, 2'd3);
        repeat (58) @(negedge clk);
        chk("mid_tx_hi", tx_b, 1);
        rst_b = 1'b0;
        #0.5;
        chk("arst_tx", tx_b, 0);
        chk("arst_busy", busy_b, 0);
        chk("arst_rdy", ifb.msg_ready, 1);
        #0.5;
        rst_b = 1'b1;
        expect_null(1, 1'b0, "post_rst");
        offer(1, 8'h90, 8'h2A, 8'h33, 2'd3);
        run_frames(1, {F90, F2A, F33}, 33, 1'b0, "post_rst_msg");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
